// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 32-way round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;
   localparam int N            = 32;
   localparam int IDX_W        = 5;
   localparam int CNT_W        = 8;
   localparam int MAX_HOLD_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [IDX_W-1:0] ffs32(input logic [N-1:0] v);
      logic [IDX_W-1:0] r;
      logic             found;
      r     = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (v[i] && !found) begin
            r     = IDX_W'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/onehot_enc32.sv
// One-hot to binary encoder for a 32-bit grant vector, gated by an enable.
// Latency: combinational, zero cycles.
// Backpressure: none; output is 0 when disabled or when the input is not one-hot.
module onehot_enc32
   import arb_pkg::*;
(
   input  logic [N-1:0]     oh,
   input  logic             en,
   output logic [IDX_W-1:0] idx
);

   logic is_onehot;
   assign is_onehot = (oh != '0) && ((oh & (oh - N'(1))) == '0);

   // OR together the indices of set bits; only meaningful when exactly one is set.
   always_comb begin
      idx = '0;
      if (en && is_onehot) begin
         for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_arb32.sv
// Round-robin arbiter: one owner of a shared resource among 32 requesters, bounded hold time.
// Latency: grant registered one cycle after request sampled; one idle cycle between grants.
// Backpressure: owner holds until done, request drop, or MAX_HOLD cycles (then timeout pulse).
module rr_arb32
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;

   // Rotating priority: rotate so ptr sits at bit 0, find first set, rotate back.
   logic [2*N-1:0]   rot_full;
   logic [N-1:0]     req_rot;
   logic [IDX_W-1:0] pick_k;
   logic [N-1:0]     pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             start;

   assign rot_full = {req, req} >> ptr;
   assign req_rot  = rot_full[N-1:0];
   assign pick_k   = ptr + ffs32(req_rot);
   assign pick_oh  = {{(N-1){1'b0}}, 1'b1} << pick_k;
   assign start    = en && (req != '0) && (state == IDLE);

   onehot_enc32 u_enc (
      .oh  (pick_oh),
      .en  (start),
      .idx (pick_idx)
   );

   // Release conditions for the current owner; done wins over the hold limit for timeout.
   logic own_req;
   logic at_limit;
   logic release_now;
   logic forced;

   assign own_req     = req[gnt_idx];
   assign at_limit    = (hold_cnt == CNT_W'(MAX_HOLD));
   assign release_now = done || !own_req || at_limit;
   assign forced      = at_limit && !done && own_req;

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else if (!en) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (start) begin
                  gnt       <= pick_oh;
                  gnt_idx   <= pick_idx;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= CNT_W'(1);
                  state     <= BUSY;
               end else begin
                  gnt       <= '0;
                  gnt_idx   <= '0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= '0;
               end
            end
            BUSY: begin
               if (release_now) begin
                  ptr       <= gnt_idx + IDX_W'(1);
                  gnt       <= '0;
                  gnt_idx   <= '0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= '0;
                  timeout   <= forced;
                  state     <= IDLE;
               end else begin
                  timeout <= 1'b0;
                  if (!at_limit) hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
